// File: rtl/alu_issue_stage.sv
// ALU issue stage: 8 x 32-bit register file feeding an external registered ALU.
// ALU ops take IDLE->EXEC->WB; load-immediate and illegal ops complete straight from IDLE.
module alu_issue_stage #(
    parameter int unsigned NREG = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [2:0]  cmd_rd,
    input  logic [2:0]  cmd_rs1,
    input  logic [2:0]  cmd_rs2,
    input  logic [31:0] cmd_imm,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [31:0] alu_out,
    input  logic        alu_ovf,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_ovf,
    output logic        rsp_err
);

    localparam int unsigned IDX_W  = $clog2(NREG);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LI  = OP_W'(15);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [OP_W-1:0]     alu_sel_q, alu_sel_d;
    logic [IDX_W-1:0]    rd_q, rd_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_ovf_q, rsp_ovf_d;
    logic                rsp_err_q, rsp_err_d;

    logic [DATA_W-1:0]   rs1_val, rs2_val;

    // R0 reads as zero regardless of storage contents
    assign rs1_val = (cmd_rs1 == '0) ? '0 : regs_q[cmd_rs1];
    assign rs2_val = (cmd_rs2 == '0) ? '0 : regs_q[cmd_rs2];

    // Ready drops for the whole reset window, not just after the first reset edge
    assign cmd_ready = rst_n && (state_q == S_IDLE);

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_err   = rsp_err_q;

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rd_d        = rd_q;
        op_d        = op_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op <= OP_SUB) begin
                        alu_a_d   = rs1_val;
                        alu_b_d   = rs2_val;
                        alu_sel_d = cmd_op;
                        rd_d      = cmd_rd;
                        op_d      = cmd_op;
                        state_d   = S_EXEC;
                    end else if (cmd_op == OP_LI) begin
                        if (cmd_rd != '0) begin
                            regs_d[cmd_rd] = cmd_imm;
                        end
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = cmd_imm;
                        rsp_ovf_d   = 1'b0;
                        rsp_err_d   = 1'b0;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_ovf_d   = 1'b0;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                // alu_out carries the result of operands sampled at the end of EXEC
                if (rd_q != '0) begin
                    regs_d[rd_q] = alu_out;
                end
                rsp_valid_d = 1'b1;
                rsp_data_d  = alu_out;
                rsp_ovf_d   = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu_ovf : 1'b0;
                rsp_err_d   = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rd_q        <= '0;
            op_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rd_q        <= rd_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: driver pushes expected responses from a
// register-array reference model, a monitor pops and compares on rsp_valid.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic [31:0] cmd_imm;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [31:0] alu_out;
    logic        alu_ovf;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_ovf;
    logic        rsp_err;

    alu_issue_stage #(.NREG(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .cmd_imm   (cmd_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_ovf   (alu_ovf),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream registered ALU; overflow on logic ops is noise the stage must mask
    logic [31:0] env_add, env_sub;
    assign env_add = alu_a + alu_b;
    assign env_sub = alu_a - alu_b;
    always @(posedge clk) begin
        case (alu_sel)
            4'd0: begin alu_out <= alu_a & alu_b; alu_ovf <= 1'($urandom); end
            4'd1: begin alu_out <= alu_a | alu_b; alu_ovf <= 1'($urandom); end
            4'd2: begin alu_out <= alu_a ^ alu_b; alu_ovf <= 1'($urandom); end
            4'd3: begin
                alu_out <= env_add;
                alu_ovf <= (alu_a[31] == alu_b[31]) && (env_add[31] != alu_a[31]);
            end
            4'd4: begin
                alu_out <= env_sub;
                alu_ovf <= (alu_a[31] != alu_b[31]) && (env_sub[31] != alu_a[31]);
            end
            default: begin alu_out <= 32'h0; alu_ovf <= 1'b0; end
        endcase
    end

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        logic        err;
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ready_at = 0;

    logic [31:0] model_r [8];
    logic [31:0] last_a, last_b;
    logic [3:0]  last_sel;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] rreg(input logic [2:0] idx);
        return (idx == 3'd0) ? 32'h0 : model_r[idx];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) model_r[i] = 32'h0;
        last_a   = 32'h0;
        last_b   = 32'h0;
        last_sel = 4'h0;
    endfunction

    // Reference model: architectural effect of one accepted command
    function automatic void model_accept(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [2:0] rs2,
                                         input logic [31:0] imm, input int n);
        exp_t   e;
        logic [31:0] a, b;
        longint full;
        a = rreg(rs1);
        b = rreg(rs2);
        e.ovf = 1'b0;
        e.err = 1'b0;
        if (op <= 4'd4) begin
            case (op)
                4'd0: e.data = a & b;
                4'd1: e.data = a | b;
                4'd2: e.data = a ^ b;
                default: begin
                    if (op == 4'd3) full = longint'($signed(a)) + longint'($signed(b));
                    else            full = longint'($signed(a)) - longint'($signed(b));
                    e.data = 32'(full);
                    e.ovf  = (full > SMAX) || (full < SMIN);
                end
            endcase
            if (rd != 3'd0) model_r[rd] = e.data;
            last_a   = a;
            last_b   = b;
            last_sel = op;
            e.cyc    = n + 3;
        end else if (op == 4'd15) begin
            e.data = imm;
            if (rd != 3'd0) model_r[rd] = imm;
            e.cyc  = n + 1;
        end else begin
            e.data = 32'h0;
            e.err  = 1'b1;
            e.cyc  = n + 1;
        end
        e.a   = last_a;
        e.b   = last_b;
        e.sel = last_sel;
        ready_at = e.cyc;
        expq.push_back(e);
    endfunction

    task automatic drive_garbage();
        cmd_op  = 4'($urandom);
        cmd_rd  = 3'($urandom);
        cmd_rs1 = 3'($urandom);
        cmd_rs2 = 3'($urandom);
        cmd_imm = $urandom;
    endtask

    // Present one command, jittering cmd_* while the stage is busy
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [31:0] imm, input bit track);
        int waits = 0;
        bit go = 1'b0;
        int n;
        @(negedge clk);
        while (!go) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(cyc >= ready_at));
            if (cmd_ready === 1'b1) begin
                go = 1'b1;
            end else begin
                waits++;
                if (waits > 10) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL accept_timeout: cmd_ready low for %0d cycles, required <= 10", waits);
                    cmd_valid = 1'b0;
                    return;
                end
                cmd_valid = 1'b1;
                drive_garbage();
                @(negedge clk);
            end
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_imm   = imm;
        n = cyc;
        @(posedge clk);
        if (track) model_accept(op, rd, rs1, rs2, imm, n);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            drive_garbage();
        end
    endtask

    // Monitor: flag overdue responses, then compare any presented response
    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_missing: no rsp_valid at cycle %0d, required by cycle %0d", cyc, expq[0].cyc);
            void'(expq.pop_front());
        end
        if (rsp_valid === 1'b1) begin
            if (expq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: rsp_valid=1 data=0x%08h at cycle %0d, required no response", rsp_data, cyc);
            end else begin
                mon_e = expq.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("rsp_data",  rsp_data, mon_e.data);
                chk("rsp_ovf",   32'(rsp_ovf), 32'(mon_e.ovf));
                chk("rsp_err",   32'(rsp_err), 32'(mon_e.err));
                chk("alu_a",     alu_a, mon_e.a);
                chk("alu_b",     alu_b, mon_e.b);
                chk("alu_sel",   32'(alu_sel), 32'(mon_e.sel));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t exceeded limit 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] imm;
        int          u;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_rd    = 3'h0;
        cmd_rs1   = 3'h0;
        cmd_rs2   = 3'h0;
        cmd_imm   = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_data",  rsp_data, 32'h0);
        chk("reset_rsp_ovf",   32'(rsp_ovf), 32'h0);
        chk("reset_rsp_err",   32'(rsp_err), 32'h0);
        chk("reset_alu_a",     alu_a, 32'h0);
        chk("reset_alu_b",     alu_b, 32'h0);
        chk("reset_alu_sel",   32'(alu_sel), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 32'(cmd_ready), 32'h1);
        ready_at = cyc;

        // Basic add, signed overflow, XOR to zero
        issue(4'd15, 3'd1, 3'd0, 3'd0, 32'h0000_0005, 1'b1);
        issue(4'd15, 3'd2, 3'd0, 3'd0, 32'h0000_0003, 1'b1);
        issue(4'd3,  3'd3, 3'd1, 3'd2, 32'h0, 1'b1);
        issue(4'd15, 3'd1, 3'd0, 3'd0, 32'h7FFF_FFFF, 1'b1);
        issue(4'd15, 3'd2, 3'd0, 3'd0, 32'h0000_0001, 1'b1);
        issue(4'd3,  3'd4, 3'd1, 3'd2, 32'h0, 1'b1);
        issue(4'd2,  3'd5, 3'd4, 3'd4, 32'h0, 1'b1);
        // Illegal op, R0 hardwiring
        issue(4'd7,  3'd1, 3'd2, 3'd3, 32'h1234_5678, 1'b1);
        issue(4'd15, 3'd0, 3'd0, 3'd0, 32'hDEAD_BEEF, 1'b1);
        issue(4'd0,  3'd6, 3'd0, 3'd0, 32'h0, 1'b1);
        // Back-to-back dependent ALU chain with cmd_valid held high
        issue(4'd3,  3'd1, 3'd1, 3'd2, 32'h0, 1'b1);
        issue(4'd4,  3'd3, 3'd1, 3'd2, 32'h0, 1'b1);
        issue(4'd1,  3'd4, 3'd3, 3'd1, 32'h0, 1'b1);
        issue(4'd4,  3'd5, 3'd4, 3'd3, 32'h0, 1'b1);
        idle(2);

        for (int i = 0; i < 200; i++) begin
            u = int'($urandom_range(0, 9));
            if (u <= 4)      op = 4'(u);
            else if (u <= 6) op = 4'd15;
            else if (u == 7) op = 4'($urandom_range(5, 14));
            else             op = 4'($urandom_range(3, 4));
            case ($urandom_range(0, 4))
                0:       imm = 32'h7FFF_FFFF;
                1:       imm = 32'h8000_0000;
                2:       imm = 32'hFFFF_FFFF;
                default: imm = $urandom;
            endcase
            issue(op, 3'($urandom), 3'($urandom), 3'($urandom), imm, 1'b1);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        // Reset during WB of SUB rd=2 aborts the write and the response
        idle(1);
        issue(4'd15, 3'd1, 3'd0, 3'd0, 32'h0000_0100, 1'b1);
        issue(4'd4,  3'd2, 3'd1, 3'd0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("abort_alu_sel",   32'(alu_sel), 32'h0);
        chk("abort_rsp_data",  rsp_data, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("abort_ready_after", 32'(cmd_ready), 32'h1);
        model_reset();
        ready_at = cyc;

        // Read every register back through OR into R0
        for (int r = 1; r < 8; r++) begin
            issue(4'd1, 3'd0, 3'(r), 3'(r), 32'h0, 1'b1);
        end
        idle(6);
        chk("queue_drained", 32'(expq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter: NREG, 8, number of 32-bit architectural registers (fixed at 8; index width 3).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port: cmd_valid  input  1  command present.
REQ-005 SHALL have port: cmd_ready  output  1  stage can accept a command.
REQ-006 SHALL have port: cmd_op  input  4  0=AND, 1=OR, 2=XOR, 3=ADD, 4=SUB, 15=load immediate, 5-14 illegal.
REQ-007 SHALL have ports: cmd_rd, cmd_rs1, cmd_rs2  input  3 each  destination, source A, source B register indices.
REQ-008 SHALL have port: cmd_imm  input  32  immediate for op 15.
REQ-009 SHALL have ports: alu_a, alu_b  output  32 each; alu_sel  output  4  operands/select to the downstream 32-bit ALU.
REQ-010 SHALL have ports: alu_out  input  32; alu_ovf  input  1  registered ALU result/overflow, valid one clock after operands are sampled.
REQ-011 SHALL have ports: rsp_valid  output  1; rsp_data  output  32; rsp_ovf  output  1; rsp_err  output  1  completion report.

Function
REQ-012 SHALL accept a command on a rising edge where cmd_valid && cmd_ready; cmd_ready SHALL be 1 only in state IDLE.
REQ-013 SHALL implement FSM states IDLE, EXEC, WB; IDLE->EXEC on accepting ops 0-4; EXEC->WB unconditionally; WB->IDLE unconditionally; ops 15 and 5-14 SHALL stay in IDLE.
REQ-014 SHALL, at the accept edge of ops 0-4, load alu_a <= R[rs1], alu_b <= R[rs2], alu_sel <= cmd_op, latch rd and op; these outputs SHALL hold stable through EXEC and WB and until the next accepted ALU op.
REQ-015 SHALL, at the edge ending WB, write alu_out to R[rd] and load rsp_data <= alu_out, rsp_ovf <= alu_ovf if op is 3 or 4 else 0, rsp_err <= 0.
REQ-016 SHALL assert rsp_valid for exactly one cycle, the cycle after the result edge; latency accept edge -> rsp_valid = 3 cycles for ALU ops.
REQ-017 SHALL, for op 15 at the accept edge, write cmd_imm to R[rd] and load rsp_data <= cmd_imm, rsp_ovf <= 0, rsp_err <= 0; rsp_valid next cycle (1-cycle latency).
REQ-018 SHALL, for ops 5-14, not write any register, not change alu_* outputs, and report rsp_data=0, rsp_ovf=0, rsp_err=1 next cycle.
REQ-019 SHALL hardwire R0 to zero: reads return 0; writes discarded; response still reported with the computed/imm data.
REQ-020 SHALL allow back-to-back commands: after WB, state is IDLE and a new command may be accepted the same cycle rsp_valid is high; it SHALL read updated register values (no hazard, no forwarding needed).
REQ-021 SHALL ignore cmd_valid and all cmd_* inputs while cmd_ready is 0.
REQ-022 SHALL perform all arithmetic in the ALU; this block SHALL do no width extension or truncation; all data is 32-bit.

Reset
REQ-023 SHALL, on any rising edge with rst_n=0, set state IDLE, R1-R7 to 0, alu_a/alu_b to 0, alu_sel to 0, rsp_valid/rsp_ovf/rsp_err to 0, rsp_data to 0.
REQ-024 SHALL, on reset during EXEC or WB, abort the op: no register write, no rsp_valid; cmd_ready=0 during reset cycles, 1 in first cycle after rst_n returns high.

Verification
REQ-025 SHALL pass: load R1=0x0000_0005, R2=0x0000_0003, ADD rd=3 -> rsp_valid 3 cycles after accept, rsp_data=0x0000_0008, rsp_ovf=0; R3=8.
REQ-026 SHALL pass: load R1=0x7FFF_FFFF, R2=1, ADD rd=4 -> rsp_data=0x8000_0000, rsp_ovf=1; then XOR R4,R4 -> rsp_data=0, rsp_ovf=0.
REQ-027 SHALL pass: op=7 -> rsp_valid next cycle with rsp_err=1, rsp_data=0; alu_sel unchanged; no register changes.
REQ-028 SHALL pass: load rd=0 imm=0xDEAD_BEEF -> rsp_data=0xDEAD_BEEF; subsequent AND R0,R0 -> rsp_data=0.
REQ-029 SHALL pass: cmd_valid held high with 4 queued ALU ops -> accepts exactly every 3 cycles, cmd_ready low in EXEC/WB, results chain (SUB using prior result reads updated value).
REQ-030 SHALL pass: rst_n low during WB of SUB rd=2 -> R2 stays 0, no rsp_valid, cmd_ready=1 the cycle after rst_n deasserts.
